// File: rtl/uart_rx_display_if.sv
// rtl/uart_rx_display_if.sv - serial input and display-side outputs of the UART display front end
interface uart_rx_display_if;
    logic        rx;
    logic [15:0] x;
    logic        cclk;
    logic        rx_done;
    logic        frame_err;
    logic        rx_busy;

    modport master (
        output rx,
        input  x,
        input  cclk,
        input  rx_done,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  rx,
        output x,
        output cclk,
        output rx_done,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx_display.sv
// rtl/uart_rx_display.sv - 8N1 UART receiver feeding a two-byte display word plus display scan clock
module uart_rx_display #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int REFRESH_BITS = 18
) (
    input  logic             clk,
    input  logic             clr,
    uart_rx_display_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    logic                    r_rx1;
    logic                    r_rx2;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic [2:0]              r_state;
    logic [CNT_W-1:0]        r_clk_cnt;
    logic [2:0]              r_bit_idx;
    logic [7:0]              r_shift;
    logic [15:0]             r_x;
    logic                    r_done;
    logic                    r_ferr;
    logic                    w_rxs;

    assign w_rxs         = r_rx2;
    assign bus.x         = r_x;
    assign bus.cclk      = r_refresh[REFRESH_BITS-1];
    assign bus.rx_done   = r_done;
    assign bus.frame_err = r_ferr;
    assign bus.rx_busy   = (r_state != IDLE);

    // Two-flop synchronizer on the asynchronous line; resets to idle-high so reset never looks like a start bit
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rx1 <= 1'b1;
            r_rx2 <= 1'b1;
        end else begin
            r_rx1 <= bus.rx;
            r_rx2 <= r_rx1;
        end
    end

    // Free-running refresh counter; its MSB is the display scan clock
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_refresh <= '0;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    // Receive FSM: centre-samples each bit, commits a byte to x only on a good stop bit
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_x       <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state   <= START;
                        r_clk_cnt <= '0;
                    end
                end
                START: begin
                    if (r_clk_cnt == HALF_M1) begin
                        r_clk_cnt <= '0;
                        if (!w_rxs) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_clk_cnt == FULL_M1) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rxs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_clk_cnt == FULL_M1) begin
                        r_clk_cnt <= '0;
                        if (w_rxs) begin
                            r_x     <= {r_x[7:0], r_shift};
                            r_done  <= 1'b1;
                            r_ferr  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= WAIT_IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (w_rxs) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_display.sv
// tb/tb_uart_rx_display.sv - directed bench for uart_rx_display
module tb_uart_rx_display;
    localparam int CPB = 16;
    localparam int RB  = 4;

    logic clk;
    logic clr;
    int   n_tests;
    int   n_fail;
    int   done_cnt;
    int   dbl_done;
    int   x_glitch;
    logic prev_done;
    logic [15:0] prev_x;

    uart_rx_display_if bus_if ();

    uart_rx_display #(
        .CLKS_PER_BIT(CPB),
        .REFRESH_BITS(RB)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watch for multi-cycle rx_done and x moving outside an rx_done cycle
    always @(negedge clk) begin
        if (clr) begin
            prev_done = 1'b0;
            prev_x    = bus_if.x;
        end else begin
            if (bus_if.rx_done === 1'b1) begin
                done_cnt = done_cnt + 1;
                if (prev_done) dbl_done = dbl_done + 1;
            end else if (bus_if.x !== prev_x) begin
                x_glitch = x_glitch + 1;
            end
            prev_done = (bus_if.rx_done === 1'b1);
            prev_x    = bus_if.x;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus_if.rx = b;
        wait_clk(CPB);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    int   toggles;
    int   base;
    logic last_cclk;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        done_cnt = 0;
        dbl_done = 0;
        x_glitch = 0;
        prev_done = 1'b0;
        prev_x    = 16'h0;
        clr       = 1'b1;
        bus_if.rx = 1'b1;
        wait_clk(3);
        check("reset_x", {16'h0, bus_if.x}, 32'h0);
        check("reset_busy", {31'h0, bus_if.rx_busy}, 32'h0);
        check("reset_ferr", {31'h0, bus_if.frame_err}, 32'h0);
        check("reset_done", {31'h0, bus_if.rx_done}, 32'h0);
        check("reset_cclk", {31'h0, bus_if.cclk}, 32'h0);
        clr = 1'b0;

        // Idle: count cclk transitions over 64 clocks, expect one every 8
        toggles = 0;
        @(negedge clk);
        last_cclk = bus_if.cclk;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus_if.cclk !== last_cclk) toggles++;
            last_cclk = bus_if.cclk;
        end
        wait_clk(36);
        check("cclk_toggles", toggles, 32'd8);
        check("idle_x", {16'h0, bus_if.x}, 32'h0);
        check("idle_busy", {31'h0, bus_if.rx_busy}, 32'h0);
        check("idle_ferr", {31'h0, bus_if.frame_err}, 32'h0);
        check("idle_done_cnt", done_cnt, 32'd0);

        // Two good bytes
        base = done_cnt;
        send_byte(8'h41, 1'b1);
        wait_clk(20);
        check("byte1_x", {16'h0, bus_if.x}, 32'h0041);
        check("byte1_done", done_cnt - base, 32'd1);
        send_byte(8'h5A, 1'b1);
        wait_clk(20);
        check("byte2_x", {16'h0, bus_if.x}, 32'h415A);
        check("byte2_done", done_cnt - base, 32'd2);
        check("byte2_ferr", {31'h0, bus_if.frame_err}, 32'h0);

        // Bad stop bit, line held low, then released
        base = done_cnt;
        send_byte(8'h12, 1'b0);
        check("ferr_set", {31'h0, bus_if.frame_err}, 32'h1);
        check("ferr_wait_busy", {31'h0, bus_if.rx_busy}, 32'h1);
        wait_clk(40);
        check("ferr_held_busy", {31'h0, bus_if.rx_busy}, 32'h1);
        bus_if.rx = 1'b1;
        wait_clk(20);
        check("ferr_release_busy", {31'h0, bus_if.rx_busy}, 32'h0);
        check("ferr_x", {16'h0, bus_if.x}, 32'h415A);
        check("ferr_no_done", done_cnt - base, 32'd0);
        check("ferr_sticky", {31'h0, bus_if.frame_err}, 32'h1);
        send_byte(8'h34, 1'b1);
        wait_clk(20);
        check("ferr_clear", {31'h0, bus_if.frame_err}, 32'h0);
        check("after_ferr_x", {16'h0, bus_if.x}, 32'h5A34);

        // Short low glitch on idle line
        base = done_cnt;
        bus_if.rx = 1'b0;
        wait_clk(5);
        check("glitch_busy", {31'h0, bus_if.rx_busy}, 32'h1);
        bus_if.rx = 1'b1;
        wait_clk(30);
        check("glitch_idle", {31'h0, bus_if.rx_busy}, 32'h0);
        check("glitch_x", {16'h0, bus_if.x}, 32'h5A34);
        check("glitch_no_done", done_cnt - base, 32'd0);
        check("glitch_ferr", {31'h0, bus_if.frame_err}, 32'h0);

        // Back-to-back frames with no idle gap
        base = done_cnt;
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_clk(20);
        check("b2b_x", {16'h0, bus_if.x}, 32'hC3FF);
        check("b2b_done", done_cnt - base, 32'd3);

        // Reset in the middle of data bit 4 of 0x77
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1 & (8'h77 >> i));
        bus_if.rx = 1'b1;
        wait_clk(8);
        clr = 1'b1;
        #1;
        check("midclr_x", {16'h0, bus_if.x}, 32'h0);
        check("midclr_busy", {31'h0, bus_if.rx_busy}, 32'h0);
        wait_clk(3);
        clr = 1'b0;
        base = done_cnt;
        wait_clk(20);
        check("postclr_busy", {31'h0, bus_if.rx_busy}, 32'h0);
        check("postclr_x", {16'h0, bus_if.x}, 32'h0);
        send_byte(8'hA5, 1'b1);
        wait_clk(20);
        check("postclr_byte_x", {16'h0, bus_if.x}, 32'h00A5);
        check("postclr_done", done_cnt - base, 32'd1);
        check("postclr_ferr", {31'h0, bus_if.frame_err}, 32'h0);

        check("done_single_cycle", dbl_done, 32'd0);
        check("x_only_on_done", x_glitch, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_display.md
Name: uart_rx_display

Overview:
- Serial front end for the 4-digit hex display driver.
- Receives 8N1 UART bytes on one pin and shifts each good byte into a 16-bit display word `x`, so the display shows the last two bytes received: newest byte in `x[7:0]`, previous byte in `x[15:8]`.
- Also generates the slow scan clock `cclk` that the display driver uses to multiplex its digits.
- Sits between the board RX pin and the display driver.

Parameters:
- CLKS_PER_BIT, 5208, system clocks per UART bit (50 MHz / 9600 baud); minimum 4.
- REFRESH_BITS, 18, width of the free-running refresh counter; its MSB is driven out as `cclk`.

Ports:
- clk  input  1  system clock, all logic on rising edge
- clr  input  1  reset, asynchronous, active-high
- rx  input  1  raw serial line; idles high; asynchronous to clk
- x  output  16  display word: {previous byte, newest byte}
- cclk  output  1  display scan clock = MSB of refresh counter
- rx_done  output  1  one-clk pulse when a byte is accepted into x
- frame_err  output  1  sticky framing-error flag
- rx_busy  output  1  high while the FSM is not in IDLE

Behaviour:
- Reset (clr=1, asynchronous):
  - x=16'h0000, rx_done=0, frame_err=0, rx_busy=0.
  - Refresh counter=0, so cclk=0.
  - FSM=IDLE; bit counter, clock counter and shift register all cleared.
  - Both synchronizer flops are set to 1 (line idle).
- rx synchronizer: two flops; the FSM sees only the second flop (`rxs`). Rx-to-FSM latency is 2 clk.
- Refresh counter:
  - Increments every clk and wraps at 2^REFRESH_BITS.
  - cclk toggles every 2^(REFRESH_BITS-1) clk and is independent of the FSM.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when rxs=0, go to START with clock counter=0.
- START:
  - Count to CLKS_PER_BIT/2-1 (integer divide), which is mid start bit.
  - If rxs=0 there: go to DATA, counter=0, bit index=0.
  - If rxs=1 there: glitch; return to IDLE with no output change.
- DATA:
  - Every CLKS_PER_BIT clocks, sample rxs into the shift register, LSB first.
  - After the 8th sample, go to STOP.
- STOP: after CLKS_PER_BIT clocks, sample rxs.
  - rxs=1: x <= {x[7:0], shift[7:0]}, rx_done=1 for exactly one clk, frame_err <= 0; go to IDLE.
  - rxs=0: frame_err <= 1, x unchanged, no rx_done; go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs=1, then go to IDLE. This prevents a held-low line (break) from retriggering starts.
- frame_err: set only by a bad stop bit, cleared only by the next good byte or by clr.
- Timing: rx_done asserts CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clk after the first clk in which rxs=0 (±1 clk sampling uncertainty relative to the rx pin, plus 2 synchronizer clk).
- Back-to-back frames: the FSM is in IDLE by the end of the stop-bit centre, so a start edge arriving half a bit later is caught. Frames with no idle gap must be received without loss.
- rx_busy = (state != IDLE), registered with the state.
- Reset mid-frame: the partial byte is discarded and x is cleared. If clr deasserts while rx is low, that low is treated as a start bit; a resulting bad frame is reported through frame_err / WAIT_IDLE only.
- x changes only in the clk cycle where rx_done=1, so the display never shows a partial byte.

Test Plan (CLKS_PER_BIT=16, REFRESH_BITS=4):
- Reset, then idle for 100 clk -> x=0000, rx_busy=0, frame_err=0; cclk toggles every 8 clk (period 16).
- Send 0x41, then 0x5A (8N1, LSB first, 1 stop bit) -> x=0041 after the first rx_done, then x=415A; exactly two single-cycle rx_done pulses.
- Send 0x12 with stop bit=0, then release the line high -> frame_err=1, x unchanged, no rx_done. Then send 0x34 -> frame_err=0, x={old low byte, 34}.
- Drive a 5-clk low glitch on idle rx -> FSM returns to IDLE, no rx_done, x unchanged.
- Send 0x3C, 0xC3, 0xFF with no idle gap between frames -> x=C3FF at the end, three rx_done pulses.
- Assert clr during data bit 4 of 0x77, release it with rx high, then send 0xA5 -> x=0000 after reset, then x=00A5.
